// File: rtl/error_readout_sequencer_if.sv
// Readout data channel between error_readout_sequencer and the downstream
// service-record/readout FIFO.
//
//   DataOut    sequencer -> FIFO   {marker, index, count} word
//   DataValid  sequencer -> FIFO   DataOut holds a word
//   DataReady  FIFO -> sequencer   word accepted on a posedge with DataValid
//
// The master modport is the sequencer side and the slave modport is the FIFO side.
interface error_readout_sequencer_if #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0] DataOut;
   logic              DataValid;
   logic              DataReady;

   modport master (
      output DataOut,
      output DataValid,
      input  DataReady
   );

   modport slave (
      input  DataOut,
      input  DataValid,
      output DataReady
   );
endinterface

// File: rtl/error_readout_sequencer.sv
// error_readout_sequencer
//
// Scans a bank of N_COUNTERS error counters one after another. For each
// counter it enables that counter onto the shared count bus for one cycle,
// captures the count, and sends a tagged word {1, index, count} downstream.
// It can optionally pulse the counter's clear line after the read. Each scan
// ends with a trailer word {0, all-ones index, number of words sent}.
//
// Ports:
//   Clk             clock; all logic runs on posedge
//   Reset           asynchronous, active-low reset
//   ReadStart       starts a scan; only honoured while idle
//   ClearAfterRead  pulse ErrorReset after each read (latched at scan start)
//   SkipZero        suppress words whose count is zero (latched at scan start)
//   ErrorFlags      per-counter error lines
//   ErrorCount      shared count bus, driven by the counter selected by ErrorRead
//   ErrorRead       one-hot bus-drive enables, high only in SELECT
//   ErrorReset      per-counter one-cycle clear pulses
//   dout            readout data channel (DataOut/DataValid/DataReady)
//   Busy            scan in progress
//   ErrorPending    registered OR of ErrorFlags
//
// Optional build macro ERR_SEQ_TMR_EN: when defined, the state, index, word
// count, captured count and latched config bits are held in three copies.
// Every copy is rewritten each cycle from the 2-of-3 vote, so an upset in a
// single copy is corrected on the next edge. The outputs follow the voted
// values, so the upset never reaches them.
module error_readout_sequencer #(
   parameter int unsigned N_COUNTERS = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned CNT_W      = 10
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      ReadStart,
   input  logic                      ClearAfterRead,
   input  logic                      SkipZero,
   input  logic [N_COUNTERS-1:0]     ErrorFlags,
   input  logic [CNT_W-1:0]          ErrorCount,
   output logic [N_COUNTERS-1:0]     ErrorRead,
   output logic [N_COUNTERS-1:0]     ErrorReset,
   error_readout_sequencer_if.master dout,
   output logic                      Busy,
   output logic                      ErrorPending
);

   localparam int unsigned DATA_W  = 1 + ADDR_W + CNT_W;
   // Enough bits to count every counter of a full scan.
   localparam int unsigned WORDS_W = ADDR_W + 1;

`ifdef ERR_SEQ_TMR_EN
   localparam int unsigned NCOPY = 3;
`else
   localparam int unsigned NCOPY = 1;
`endif

   localparam logic [ADDR_W-1:0]     LAST_IDX = ADDR_W'(N_COUNTERS - 1);
   localparam logic [N_COUNTERS-1:0] ONE_HOT0 = N_COUNTERS'(1);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      EMIT,
      CLEAR,
      TRAILER
   } state_t;

   // Register copies (one copy, or three under ERR_SEQ_TMR_EN).
   state_t             st_q    [NCOPY];
   logic [ADDR_W-1:0]  idx_q   [NCOPY];
   logic [WORDS_W-1:0] words_q [NCOPY];
   logic [CNT_W-1:0]   cap_q   [NCOPY];
   logic               clr_q   [NCOPY];
   logic               skip_q  [NCOPY];

   // Voted values; all decisions are made on these.
   state_t             st;
   logic [ADDR_W-1:0]  idx;
   logic [WORDS_W-1:0] words;
   logic [CNT_W-1:0]   cap;
   logic               clr;
   logic               skip;

   always_comb begin
`ifdef ERR_SEQ_TMR_EN
      st    = state_t'((st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]));
      idx   = (idx_q[0] & idx_q[1]) | (idx_q[0] & idx_q[2]) | (idx_q[1] & idx_q[2]);
      words = (words_q[0] & words_q[1]) | (words_q[0] & words_q[2]) | (words_q[1] & words_q[2]);
      cap   = (cap_q[0] & cap_q[1]) | (cap_q[0] & cap_q[2]) | (cap_q[1] & cap_q[2]);
      clr   = (clr_q[0] & clr_q[1]) | (clr_q[0] & clr_q[2]) | (clr_q[1] & clr_q[2]);
      skip  = (skip_q[0] & skip_q[1]) | (skip_q[0] & skip_q[2]) | (skip_q[1] & skip_q[2]);
`else
      st    = st_q[0];
      idx   = idx_q[0];
      words = words_q[0];
      cap   = cap_q[0];
      clr   = clr_q[0];
      skip  = skip_q[0];
`endif
   end

   // Derived values used by the FSM.
   logic [ADDR_W-1:0]     idx_inc;
   logic [WORDS_W-1:0]    words_inc;
   logic                  last;
   logic                  bus_zero;
   logic [N_COUNTERS-1:0] sel_cur;
   logic [N_COUNTERS-1:0] sel_inc;
   logic [DATA_W-1:0]     word_bus;
   logic [DATA_W-1:0]     word_cap;
   logic [DATA_W-1:0]     trailer_cur;
   logic [DATA_W-1:0]     trailer_inc;

   always_comb begin
      idx_inc     = idx + 1'b1;
      words_inc   = words + 1'b1;
      last        = (idx == LAST_IDX);
      bus_zero    = (ErrorCount == '0);
      sel_cur     = ONE_HOT0 << idx;
      sel_inc     = ONE_HOT0 << idx_inc;
      word_bus    = {1'b1, idx, ErrorCount};
      word_cap    = {1'b1, idx, cap};
      trailer_cur = {1'b0, {ADDR_W{1'b1}}, CNT_W'(words)};
      trailer_inc = {1'b0, {ADDR_W{1'b1}}, CNT_W'(words_inc)};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         st_q           <= '{default: IDLE};
         idx_q          <= '{default: '0};
         words_q        <= '{default: '0};
         cap_q          <= '{default: '0};
         clr_q          <= '{default: 1'b0};
         skip_q         <= '{default: 1'b0};
         ErrorRead      <= '0;
         ErrorReset     <= '0;
         dout.DataOut   <= '0;
         dout.DataValid <= 1'b0;
         Busy           <= 1'b0;
         ErrorPending   <= 1'b0;
      end else begin
         ErrorPending <= |ErrorFlags;

         // Every copy is rewritten from the vote each cycle; the state
         // branches below override individual fields as needed.
         st_q    <= '{default: st};
         idx_q   <= '{default: idx};
         words_q <= '{default: words};
         cap_q   <= '{default: cap};
         clr_q   <= '{default: clr};
         skip_q  <= '{default: skip};

         // Both strobes are single-cycle: anything not re-asserted below drops.
         ErrorRead  <= '0;
         ErrorReset <= '0;

         case (st)
            IDLE: begin
               if (ReadStart) begin
                  clr_q     <= '{default: ClearAfterRead};
                  skip_q    <= '{default: SkipZero};
                  idx_q     <= '{default: '0};
                  words_q   <= '{default: '0};
                  ErrorRead <= ONE_HOT0;
                  Busy      <= 1'b1;
                  st_q      <= '{default: SELECT};
               end
            end

            SELECT: begin
               cap_q <= '{default: ErrorCount};
               if (skip && bus_zero) begin
                  // Suppressed word: skip EMIT entirely so a zero counter
                  // costs only this cycle when not clearing.
                  if (clr) begin
                     ErrorReset <= sel_cur;
                     st_q       <= '{default: CLEAR};
                  end else if (last) begin
                     dout.DataOut   <= trailer_cur;
                     dout.DataValid <= 1'b1;
                     st_q           <= '{default: TRAILER};
                  end else begin
                     idx_q     <= '{default: idx_inc};
                     ErrorRead <= sel_inc;
                     st_q      <= '{default: SELECT};
                  end
               end else begin
                  dout.DataOut   <= word_bus;
                  dout.DataValid <= 1'b1;
                  st_q           <= '{default: EMIT};
               end
            end

            EMIT: begin
               if (dout.DataReady) begin
                  dout.DataValid <= 1'b0;
                  words_q        <= '{default: words_inc};
                  if (clr) begin
                     ErrorReset <= sel_cur;
                     st_q       <= '{default: CLEAR};
                  end else if (last) begin
                     dout.DataOut   <= trailer_inc;
                     dout.DataValid <= 1'b1;
                     st_q           <= '{default: TRAILER};
                  end else begin
                     idx_q     <= '{default: idx_inc};
                     ErrorRead <= sel_inc;
                     st_q      <= '{default: SELECT};
                  end
               end else begin
                  dout.DataOut <= word_cap;
               end
            end

            CLEAR: begin
               if (last) begin
                  dout.DataOut   <= trailer_cur;
                  dout.DataValid <= 1'b1;
                  st_q           <= '{default: TRAILER};
               end else begin
                  idx_q     <= '{default: idx_inc};
                  ErrorRead <= sel_inc;
                  st_q      <= '{default: SELECT};
               end
            end

            TRAILER: begin
               if (dout.DataReady) begin
                  dout.DataValid <= 1'b0;
                  Busy           <= 1'b0;
                  st_q           <= '{default: IDLE};
               end
            end

            default: begin
               dout.DataValid <= 1'b0;
               Busy           <= 1'b0;
               st_q           <= '{default: IDLE};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_error_readout_sequencer.sv
// Testbench for error_readout_sequencer: a behavioural counter bank on the
// shared bus, directed scans, and a scoreboard of expected data words and
// expected ErrorReset pulses that a monitor thread checks on negedges.
module tb_error_readout_sequencer;

   localparam int N = 32;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          ReadStart = 1'b0;
   logic          ClearAfterRead = 1'b0;
   logic          SkipZero = 1'b0;
   logic [N-1:0]  ErrorFlags;
   logic [9:0]    ErrorCount;
   logic [N-1:0]  ErrorRead;
   logic [N-1:0]  ErrorReset;
   logic          Busy;
   logic          ErrorPending;

   logic [9:0]    cnt    [N];
   logic [9:0]    preset [N];
   logic          load_req = 1'b0;

   logic [15:0]   exp_q [$];
   int            rst_q [$];
   int            checks = 0;
   int            errors = 0;

   error_readout_sequencer_if #(.DATA_W(16)) dbus ();

   error_readout_sequencer #(
      .N_COUNTERS (32),
      .ADDR_W     (5),
      .CNT_W      (10)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .ReadStart      (ReadStart),
      .ClearAfterRead (ClearAfterRead),
      .SkipZero       (SkipZero),
      .ErrorFlags     (ErrorFlags),
      .ErrorCount     (ErrorCount),
      .ErrorRead      (ErrorRead),
      .ErrorReset     (ErrorReset),
      .dout           (dbus.master),
      .Busy           (Busy),
      .ErrorPending   (ErrorPending)
   );

   always #5 Clk = ~Clk;

   // Counter bank: updates on negedge, cleared by its ErrorReset line.
   always @(negedge Clk) begin
      for (int i = 0; i < N; i++) begin
         if (load_req) cnt[i] <= preset[i];
         else if (ErrorReset[i]) cnt[i] <= '0;
      end
   end

   // Shared count bus: only the enabled counter contributes.
   always_comb begin
      ErrorCount = '0;
      for (int i = 0; i < N; i++)
         if (ErrorRead[i]) ErrorCount = ErrorCount | cnt[i];
   end

   always_comb begin
      ErrorFlags = '0;
      for (int i = 0; i < N; i++) ErrorFlags[i] = (cnt[i] != '0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] data_word(input int i, input int c);
      return 16'h8000 | 16'(i << 10) | 16'(c);
   endfunction

   function automatic logic [15:0] trailer_word(input int n);
      return 16'h7C00 | 16'(n);
   endfunction

   task automatic load_counts(input int c0, input int c7);
      for (int i = 0; i < N; i++) preset[i] = '0;
      preset[0] = 10'(c0);
      preset[7] = 10'(c7);
      load_req = 1'b1;
      @(negedge Clk);
      #1 load_req = 1'b0;
   endtask

   task automatic start_scan(input logic clr, input logic skip);
      @(posedge Clk);
      #1;
      ClearAfterRead = clr;
      SkipZero       = skip;
      ReadStart      = 1'b1;
      @(posedge Clk);
      #1;
      ReadStart = 1'b0;
      chk("busy_set", 32'(Busy), 1);
   endtask

   task automatic wait_idle(input int max_cycles, output int n);
      n = 0;
      while (Busy && n < max_cycles) begin
         @(posedge Clk);
         #1;
         n++;
      end
      if (Busy) chk("idle_timeout", 32'(Busy), 0);
   endtask

   // Expected words for counts {idx0=c0, idx7=c7, rest 0}.
   task automatic push_scan(input int c0, input int c7, input logic skip);
      int n;
      n = 0;
      for (int i = 0; i < N; i++) begin
         int c;
         c = (i == 0) ? c0 : ((i == 7) ? c7 : 0);
         if (!skip || c != 0) begin
            exp_q.push_back(data_word(i, c));
            n++;
         end
      end
      exp_q.push_back(trailer_word(n));
   endtask

   initial begin
      int n;
      dbus.DataReady = 1'b1;

      fork
         begin
            int ri;
            forever begin
               @(negedge Clk);
               if (Busy) begin
                  chk("read_onehot", 32'($onehot0(ErrorRead)), 1);
                  chk("read_reset_overlap", 32'(|(ErrorRead & ErrorReset)), 0);
               end
               if (ErrorReset != '0) begin
                  if (rst_q.size() == 0) chk("reset_unexpected", ErrorReset, 0);
                  else begin
                     ri = rst_q.pop_front();
                     chk("reset_pulse", ErrorReset, 32'(1) << ri);
                  end
               end
               if (dbus.DataValid) begin
                  if (exp_q.size() == 0) chk("word_unexpected", 32'(dbus.DataOut), 0);
                  else if (dbus.DataReady) chk("word", 32'(dbus.DataOut), 32'(exp_q.pop_front()));
                  else chk("stall_word", 32'(dbus.DataOut), 32'(exp_q[0]));
               end
            end
         end
      join_none

      // Reset state.
      load_counts(5, 1023);
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_read", ErrorRead, 0);
      chk("rst_reset", ErrorReset, 0);
      chk("rst_dout", 32'(dbus.DataOut), 0);
      chk("rst_valid", 32'(dbus.DataValid), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_pending", 32'(ErrorPending), 0);
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      chk("pending_set", 32'(ErrorPending), 1);

      // Scan 1: all 32 words, no clear.
      push_scan(5, 1023, 1'b0);
      start_scan(1'b0, 1'b0);
      wait_idle(200, n);
      chk("scan1_cycles", n, 65);
      chk("scan1_drain", exp_q.size(), 0);
      chk("scan1_cnt0_kept", 32'(cnt[0]), 5);
      chk("scan1_cnt7_kept", 32'(cnt[7]), 1023);

      // Scan 2: zero counts skipped.
      push_scan(5, 1023, 1'b1);
      start_scan(1'b0, 1'b1);
      wait_idle(200, n);
      chk("scan2_cycles", n, 35);
      chk("scan2_drain", exp_q.size(), 0);

      // Scan 3: back-pressure on the first word.
      dbus.DataReady = 1'b0;
      push_scan(5, 1023, 1'b1);
      start_scan(1'b0, 1'b1);
      n = 0;
      while (!dbus.DataValid && n < 10) begin
         @(posedge Clk);
         #1;
         n++;
      end
      if (!dbus.DataValid) chk("valid_timeout", 32'(dbus.DataValid), 1);
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(dbus.DataValid), 1);
         chk("stall_data", 32'(dbus.DataOut), 32'h8005);
         chk("stall_read_idle", ErrorRead, 0);
         @(posedge Clk);
         #1;
      end
      dbus.DataReady = 1'b1;
      chk("pre_hs_read_idle", ErrorRead, 0);
      @(posedge Clk);
      #1;
      chk("post_hs_read1", ErrorRead, 32'h2);
      wait_idle(200, n);
      chk("scan3_drain", exp_q.size(), 0);

      // Scan 4: clear after read; then a skip scan sees only the trailer.
      push_scan(5, 1023, 1'b0);
      for (int i = 0; i < N; i++) rst_q.push_back(i);
      start_scan(1'b1, 1'b0);
      wait_idle(300, n);
      chk("scan4_cycles", n, 97);
      chk("scan4_drain", exp_q.size(), 0);
      chk("scan4_resets_done", rst_q.size(), 0);
      repeat (2) @(posedge Clk);
      #1;
      chk("pending_clear", 32'(ErrorPending), 0);
      exp_q.push_back(16'h7C00);
      start_scan(1'b0, 1'b1);
      wait_idle(200, n);
      chk("scan5_cycles", n, 33);
      chk("scan5_drain", exp_q.size(), 0);

      // Scan 6: ReadStart while busy is ignored; reset mid-scan at idx 12.
      load_counts(5, 1023);
      for (int i = 0; i < 12; i++) exp_q.push_back(data_word(i, (i == 0) ? 5 : ((i == 7) ? 1023 : 0)));
      start_scan(1'b0, 1'b0);
      repeat (4) @(posedge Clk);
      #1 ReadStart = 1'b1;
      @(posedge Clk);
      #1 ReadStart = 1'b0;
      n = 0;
      while (!ErrorRead[12] && n < 60) begin
         @(posedge Clk);
         #1;
         n++;
      end
      chk("reach_idx12", 32'(ErrorRead[12]), 1);
      Reset = 1'b0;
      #2;
      chk("async_read", ErrorRead, 0);
      chk("async_reset", ErrorReset, 0);
      chk("async_dout", 32'(dbus.DataOut), 0);
      chk("async_valid", 32'(dbus.DataValid), 0);
      chk("async_busy", 32'(Busy), 0);
      chk("async_pending", 32'(ErrorPending), 0);
      chk("partial_words", exp_q.size(), 0);
      @(posedge Clk);
      #1 Reset = 1'b1;
      push_scan(5, 1023, 1'b1);
      start_scan(1'b0, 1'b1);
      wait_idle(200, n);
      chk("restart_cycles", n, 35);
      chk("restart_drain", exp_q.size(), 0);

`ifdef ERR_SEQ_TMR_EN
      // Upset one index copy at idx 3; the vote hides it and it is rewritten.
      push_scan(5, 1023, 1'b1);
      start_scan(1'b0, 1'b1);
      n = 0;
      while (!ErrorRead[3] && n < 20) begin
         @(posedge Clk);
         #1;
         n++;
      end
      chk("reach_idx3", 32'(ErrorRead[3]), 1);
      dut.idx_q[1] = 5'd31;
      @(posedge Clk);
      #1;
      chk("tmr_scrub", 32'(dut.idx_q[1]), 4);
      wait_idle(200, n);
      chk("tmr_cycles", n, 35);
      chk("tmr_drain", exp_q.size(), 0);
`endif

      repeat (3) @(posedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
